sa_skew_feeder: RTL and testbench

Edge feeder placed directly upstream of the west (or north) boundary of the NxN systolic array of PEs. It accepts one operand matrix as N column-vector beats over a valid/ready handshake and buffers them. It then streams the operands onto N lanes with the systolic skew: lane i is delayed i cycles and zero-padded. It also generates the PE accumulate-enable window and a completion pulse.

---
 rtl/sa_skew_feeder_if.sv | 25 ++
 rtl/sa_skew_feeder.sv | 122 ++++++++++++
 tb/tb_sa_skew_feeder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_skew_feeder_if.sv
// Boundary bus of the systolic-array edge feeder: operand beat input and skewed lane output.
// Input handshake: a beat transfers on a rising clk edge where in_valid && in_ready; the
// source holds in_data stable until then. The lane side has no backpressure.
interface sa_skew_feeder_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DWIDTH-1:0]   in_data;
    logic [N*DWIDTH-1:0]   lane_out;
    logic                  pe_en;
    logic                  busy;
    logic                  done;

    modport master (
        output in_valid, in_data,
        input  in_ready, lane_out, pe_en, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, lane_out, pe_en, busy, done
    );
endinterface

// File: rtl/sa_skew_feeder.sv
// Buffers one NxN operand matrix (N column beats), then streams it onto N lanes with
// lane i delayed i cycles, zero-padded, followed by a flush window and a done pulse.
module sa_skew_feeder #(
    parameter int N      = 4,
    parameter int DWIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    sa_skew_feeder_if.slave  bus,
    output logic [2:0]       state_dbg
);
    localparam int BW = $clog2(N) + 1;
    localparam int TW = $clog2(2 * N);
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       cnt, cnt_nxt;
    logic [TW-1:0]       t, t_nxt;
    logic [N*DWIDTH-1:0] lane_q, lane_nxt;
    logic [DWIDTH-1:0]   mem [N][N];
    logic                accept;

    assign bus.in_ready = (state == IDLE) || (state == LOAD);
    assign bus.pe_en    = (state == STREAM) || (state == FLUSH);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.lane_out = lane_q;
    assign state_dbg    = state;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt   = BW'(1);
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt == BW'(N - 1)) begin
                        cnt_nxt   = '0;
                        t_nxt     = '0;
                        state_nxt = STREAM;
                    end else begin
                        cnt_nxt = cnt + BW'(1);
                    end
                end
            end
            STREAM: begin
                if (t == TW'(2 * N - 2)) begin
                    t_nxt     = '0;
                    state_nxt = FLUSH;
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            FLUSH: begin
                if (t == TW'(N - 2)) begin
                    t_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                t_nxt     = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lanes are registered from the next-state view so the value for cycle t appears
    // in the same cycle the state register shows STREAM with that t.
    always_comb begin
        lane_nxt = '0;
        if (state_nxt == STREAM) begin
            for (int i = 0; i < N; i++) begin
                if ((t_nxt >= TW'(i)) && ((t_nxt - TW'(i)) < TW'(N))) begin
                    lane_nxt[i*DWIDTH +: DWIDTH] = mem[IW'(t_nxt - TW'(i))][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            t      <= '0;
            lane_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            t      <= t_nxt;
            lane_q <= lane_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                mem[IW'(cnt)][i] <= bus.in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: an N=2 instance for the basic skew case and an N=4
// instance for gapped input, backpressure, async reset and back-to-back matrices.
module tb_sa_skew_feeder;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sa_skew_feeder_if #(.N(2), .DWIDTH(DW)) if2();
    sa_skew_feeder_if #(.N(4), .DWIDTH(DW)) if4();
    logic [2:0] st2, st4;

    sa_skew_feeder #(.N(2), .DWIDTH(DW)) dut2 (
        .clk(clk), .rstn(rstn), .bus(if2.slave), .state_dbg(st2)
    );
    sa_skew_feeder #(.N(4), .DWIDTH(DW)) dut4 (
        .clk(clk), .rstn(rstn), .bus(if4.slave), .state_dbg(st4)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [4*DW-1:0] exp_q[$];
    logic [DW-1:0]   a [4][4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*DW-1:0] beat4(input int k);
        logic [4*DW-1:0] v;
        for (int i = 0; i < 4; i++) v[i*DW +: DW] = a[k][i];
        return v;
    endfunction

    task automatic send4(input logic [4*DW-1:0] d);
        int c;
        if4.in_valid = 1'b1;
        if4.in_data  = d;
        c = 0;
        while (!if4.in_ready && c < 100) begin
            step();
            c++;
        end
        if (!if4.in_ready) check("send_timeout", 0, 1);
        step();
        if4.in_valid = 1'b0;
    endtask

    // Skewed image of a[][]: 2N-1 stream vectors followed by N-1 flush zeros.
    task automatic push_expected();
        logic [4*DW-1:0] v;
        for (int t = 0; t < 7; t++) begin
            v = '0;
            for (int i = 0; i < 4; i++) begin
                if (t - i >= 0 && t - i <= 3) v[i*DW +: DW] = a[t-i][i];
            end
            exp_q.push_back(v);
        end
        for (int f = 0; f < 3; f++) exp_q.push_back('0);
    endtask

    // Called on the t=0 STREAM cycle; ends on the IDLE cycle after done.
    task automatic check_window4(input string tag);
        for (int c = 0; c < 10; c++) begin
            check({tag, "_lane"}, if4.lane_out, exp_q.pop_front());
            check({tag, "_pe_en"}, if4.pe_en, 1'b1);
            check({tag, "_ready_low"}, if4.in_ready, 1'b0);
            check({tag, "_done_low"}, if4.done, 1'b0);
            step();
        end
        check({tag, "_done"}, if4.done, 1'b1);
        check({tag, "_pe_en_off"}, if4.pe_en, 1'b0);
        check({tag, "_busy_done"}, if4.busy, 1'b1);
        check({tag, "_lane_done"}, if4.lane_out, 128'd0);
        step();
        check({tag, "_ready_back"}, if4.in_ready, 1'b1);
        check({tag, "_busy_idle"}, if4.busy, 1'b0);
        check({tag, "_done_once"}, if4.done, 1'b0);
    endtask

    initial begin
        if2.in_valid = 1'b0;
        if2.in_data  = '0;
        if4.in_valid = 1'b0;
        if4.in_data  = '0;

        // Reset state
        #12;
        check("rst_ready", if4.in_ready, 1'b1);
        check("rst_busy", if4.busy, 1'b0);
        check("rst_pe_en", if4.pe_en, 1'b0);
        check("rst_lane", if4.lane_out, 128'd0);
        rstn = 1'b1;
        step();

        // Async reset with a partial load in flight, no clock edge needed
        for (int i = 0; i < 4; i++) a[0][i] = 32'h55 + i;
        send4(beat4(0));
        check("partial_busy", if4.busy, 1'b1);
        check("partial_state", st4, 3'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_busy", if4.busy, 1'b0);
        check("async_ready", if4.in_ready, 1'b1);
        check("async_state", st4, 3'd0);
        check("async_done", if4.done, 1'b0);
        step();
        rstn = 1'b1;
        step();

        // Basic skew, N=2: beats {1,2} then {3,4}
        if2.in_valid = 1'b1;
        if2.in_data  = {32'd2, 32'd1};
        step();
        if2.in_data  = {32'd4, 32'd3};
        step();
        if2.in_valid = 1'b0;
        check("n2_t0", if2.lane_out, {32'd0, 32'd1});
        check("n2_pe_t0", if2.pe_en, 1'b1);
        step();
        check("n2_t1", if2.lane_out, {32'd2, 32'd3});
        step();
        check("n2_t2", if2.lane_out, {32'd4, 32'd0});
        check("n2_pe_t2", if2.pe_en, 1'b1);
        step();
        check("n2_flush", if2.lane_out, 64'd0);
        check("n2_pe_flush", if2.pe_en, 1'b1);
        step();
        check("n2_done", if2.done, 1'b1);
        check("n2_pe_off", if2.pe_en, 1'b0);
        step();
        check("n2_idle_ready", if2.in_ready, 1'b1);
        check("n2_done_once", if2.done, 1'b0);

        // Gapped input, N=4: beat k lane i = 10*k+i, 3 idle cycles after beat 1
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) a[k][i] = DW'(10 * k + i);
        push_expected();
        send4(beat4(0));
        send4(beat4(1));
        for (int g = 0; g < 3; g++) begin
            check("gap_state", st4, 3'd1);
            check("gap_pe_en", if4.pe_en, 1'b0);
            check("gap_ready", if4.in_ready, 1'b1);
            step();
        end
        send4(beat4(2));
        check("gap_pre_last", if4.pe_en, 1'b0);
        send4(beat4(3));
        check("gap_stream", st4, 3'd2);
        step(); step(); step();
        check("gap_t3", if4.lane_out, {32'd3, 32'd12, 32'd21, 32'd30});
        repeat (3) void'(exp_q.pop_front());
        for (int c = 3; c < 10; c++) begin
            check("gap_lane", if4.lane_out, exp_q.pop_front());
            check("gap_pe_en_win", if4.pe_en, 1'b1);
            step();
        end
        check("gap_done", if4.done, 1'b1);
        step();

        // Reset mid-STREAM at t=2, then a fresh full load
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) a[k][i] = DW'(32'h100 * (k + 1) + i);
        for (int k = 0; k < 4; k++) send4(beat4(k));
        step(); step();
        #2 rstn = 1'b0;
        #1;
        check("mid_lane", if4.lane_out, 128'd0);
        check("mid_pe_en", if4.pe_en, 1'b0);
        check("mid_done", if4.done, 1'b0);
        check("mid_busy", if4.busy, 1'b0);
        step();
        rstn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("mid_no_done", if4.done, 1'b0);
            step();
        end
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) a[k][i] = DW'(32'h7000 + 16 * k + i);
        push_expected();
        for (int k = 0; k < 4; k++) send4(beat4(k));
        check_window4("fresh");

        // Backpressure and back-to-back: a fifth beat is held throughout STREAM
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) a[k][i] = DW'(32'hA000 + 16 * k + i);
        push_expected();
        for (int k = 0; k < 4; k++) send4(beat4(k));
        if4.in_valid = 1'b1;
        if4.in_data  = {4{32'h0000DEAD}};
        check_window4("bp");
        for (int i = 0; i < 4; i++) a[0][i] = 32'h0000DEAD;
        for (int k = 1; k < 4; k++)
            for (int i = 0; i < 4; i++) a[k][i] = DW'(1000 + 100 * k + i);
        push_expected();
        step();
        check("bp_beat0_taken", st4, 3'd1);
        for (int k = 1; k < 4; k++) send4(beat4(k));
        check_window4("b2b");
        check("exp_q_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
